rv_decode_stage: RTL

- Parametrised RV32I decode pipeline stage between fetch and execute.
- Registers the decoded control word (v2 format: widened ALU op, optional M-extension decode) with a valid/ready handshake and a one-entry skid buffer.
- Detects load-use hazards against the instruction it currently holds and inserts a single bubble.
- Flags illegal encodings instead of silently decoding them.

---
 rtl/rv_decode_stage_pkg.sv | 106 ++++++++++
 rtl/rv_decoder.sv | 153 +++++++++++++++
 rtl/rv_decode_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_pkg.sv
// Shared RV32I decode types: opcodes, funct fields, widened ALU ops and the v2 control word.
package rv_decode_stage_pkg;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011,
    OpSystem = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    F3AddSub = 3'b000,
    F3Sll    = 3'b001,
    F3Slt    = 3'b010,
    F3Sltu   = 3'b011,
    F3Xor    = 3'b100,
    F3Sr     = 3'b101,
    F3Or     = 3'b110,
    F3And    = 3'b111
  } funct3_alu_e;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  // Upper half is M-extension ops indexed directly by funct3.
  typedef enum logic [3:0] {
    AluAdd    = 4'd0,
    AluSub    = 4'd1,
    AluSll    = 4'd2,
    AluXor    = 4'd3,
    AluSrl    = 4'd4,
    AluSra    = 4'd5,
    AluOr     = 4'd6,
    AluAnd    = 4'd7,
    AluMul    = 4'd8,
    AluMulh   = 4'd9,
    AluMulhsu = 4'd10,
    AluMulhu  = 4'd11,
    AluDiv    = 4'd12,
    AluDivu   = 4'd13,
    AluRem    = 4'd14,
    AluRemu   = 4'd15
  } alu_ops_v2_e;

  typedef enum logic [2:0] {
    ImmI    = 3'd0,
    ImmS    = 3'd1,
    ImmB    = 3'd2,
    ImmU    = 3'd3,
    ImmJ    = 3'd4,
    ImmNone = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    alu_ops_v2_e aluop;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        set_lt;        // slt/sltu: subtract then keep the compare bit
    logic        cmp_unsigned;
    logic        use_rs1;
    logic        use_rs2;
    logic        load_regfile;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic        load_unsigned;
    logic        branch;
    logic [2:0]  branch_funct3;
    logic        jal;
    logic        jalr;
    logic        muldiv;
    logic        illegal;
    imm_fmt_e    imm_fmt;
  } ctrl_word_v2_t;

  localparam int unsigned CTRL_W = $bits(ctrl_word_v2_t);

  function automatic alu_ops_v2_e alu_of(input logic [2:0] f3, input logic alt);
    case (funct3_alu_e'(f3))
      F3AddSub:       return alt ? AluSub : AluAdd;
      F3Sll:          return AluSll;
      F3Slt, F3Sltu:  return AluSub;
      F3Xor:          return AluXor;
      F3Sr:           return alt ? AluSra : AluSrl;
      F3Or:           return AluOr;
      default:        return AluAnd;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I (+optional M) decoder: instruction word to control word, immediate
// and register indices, with illegal-encoding detection.
module rv_decoder
  import rv_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b0
) (
  input  logic [31:0]     instr_i,
  output ctrl_word_v2_t   ctrl_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  opcode_e     opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  logic [31:0] imm32;

  assign opc   = opcode_e'(instr_i[6:0]);
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign rs1_o = instr_i[19:15];
  assign rs2_o = instr_i[24:20];
  assign rd_o  = instr_i[11:7];

  always_comb begin
    ctrl_o         = '0;
    ctrl_o.aluop   = AluAdd;
    ctrl_o.imm_fmt = ImmNone;
    ill            = 1'b0;
    case (opc)
      OpLui: begin
        ctrl_o.imm_fmt      = ImmU;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.alu_src_imm  = 1'b1;
      end
      OpAuipc: begin
        ctrl_o.imm_fmt      = ImmU;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.alu_src_imm  = 1'b1;
        ctrl_o.alu_src_pc   = 1'b1;
      end
      OpJal: begin
        ctrl_o.imm_fmt      = ImmJ;
        ctrl_o.jal          = 1'b1;
        ctrl_o.load_regfile = 1'b1;
      end
      OpJalr: begin
        ctrl_o.imm_fmt      = ImmI;
        ctrl_o.jalr         = 1'b1;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.use_rs1      = 1'b1;
      end
      OpBranch: begin
        ctrl_o.imm_fmt       = ImmB;
        ctrl_o.branch        = 1'b1;
        ctrl_o.branch_funct3 = f3;
        ctrl_o.aluop         = AluSub;
        ctrl_o.cmp_unsigned  = f3[1];
        ctrl_o.use_rs1       = 1'b1;
        ctrl_o.use_rs2       = 1'b1;
        ill                  = (f3[2:1] == 2'b01);
      end
      OpLoad: begin
        ctrl_o.imm_fmt          = ImmI;
        ctrl_o.dmem_read        = 1'b1;
        ctrl_o.load_regfile     = 1'b1;
        ctrl_o.alu_src_imm      = 1'b1;
        ctrl_o.use_rs1          = 1'b1;
        ctrl_o.dmem_byte_enable = byte_enable(f3);
        ctrl_o.load_unsigned    = f3[2];
        ill                     = (f3[1:0] == 2'b11);
      end
      OpStore: begin
        ctrl_o.imm_fmt          = ImmS;
        ctrl_o.dmem_write       = 1'b1;
        ctrl_o.alu_src_imm      = 1'b1;
        ctrl_o.use_rs1          = 1'b1;
        ctrl_o.use_rs2          = 1'b1;
        ctrl_o.dmem_byte_enable = byte_enable(f3);
        ill                     = (f3 >= 3'b011);
      end
      OpImm: begin
        ctrl_o.imm_fmt      = ImmI;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.alu_src_imm  = 1'b1;
        ctrl_o.use_rs1      = 1'b1;
        ctrl_o.aluop        = alu_of(f3, (f3 == F3Sr) && (f7 == F7Alt));
        ctrl_o.set_lt       = (f3[2:1] == 2'b01);
        ctrl_o.cmp_unsigned = (f3 == F3Sltu);
        if (f3 == F3Sll) ill = (f7 != F7Base);
        else if (f3 == F3Sr) ill = (f7 != F7Base) && (f7 != F7Alt);
      end
      OpReg: begin
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.use_rs1      = 1'b1;
        ctrl_o.use_rs2      = 1'b1;
        if (f7 == F7MulDiv) begin
          if (EN_M) begin
            ctrl_o.muldiv = 1'b1;
            ctrl_o.aluop  = alu_ops_v2_e'({1'b1, f3});
          end else begin
            ill = 1'b1;
          end
        end else if (f7 == F7Base) begin
          ctrl_o.aluop        = alu_of(f3, 1'b0);
          ctrl_o.set_lt       = (f3[2:1] == 2'b01);
          ctrl_o.cmp_unsigned = (f3 == F3Sltu);
        end else if (f7 == F7Alt) begin
          ctrl_o.aluop = alu_of(f3, 1'b1);
          ill          = (f3 != F3AddSub) && (f3 != F3Sr);
        end else begin
          ill = 1'b1;
        end
      end
      OpSystem: ; // csr: treated as a nop
      default: ill = 1'b1;
    endcase

    if (ill) begin
      ctrl_o.load_regfile = 1'b0;
      ctrl_o.dmem_read    = 1'b0;
      ctrl_o.dmem_write   = 1'b0;
      ctrl_o.jal          = 1'b0;
      ctrl_o.jalr         = 1'b0;
    end
    if (rd_o == 5'd0) ctrl_o.load_regfile = 1'b0;
    ctrl_o.illegal = ill;
  end

  assign illegal_o = ill;

  always_comb begin
    case (ctrl_o.imm_fmt)
      ImmI:    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      ImmS:    imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      ImmB:    imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                        instr_i[11:8], 1'b0};
      ImmU:    imm32 = {instr_i[31:12], 12'b0};
      ImmJ:    imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                        instr_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// Decode pipeline stage: registered decoded instruction with valid/ready handshake,
// optional one-entry skid buffer, load-use bubble insertion and flush.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b0,
  parameter bit          SKID = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   in_pc_i,
  input  logic [31:0]       in_instr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_pc_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [4:0]        out_rs1_o,
  output logic [4:0]        out_rs2_o,
  output logic [4:0]        out_rd_o,
  output logic [XLEN-1:0]   out_imm_o,
  output logic              out_illegal_o,
  output logic              hazard_stall_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    ctrl_word_v2_t   ctrl;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
  } entry_t;

  ctrl_word_v2_t   dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic            dec_illegal;

  entry_t in_entry;
  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   hazard, out_load, in_ready, accept;

  rv_decoder #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_decoder (
    .instr_i   (in_instr_i),
    .ctrl_o    (dec_ctrl),
    .imm_o     (dec_imm),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .rd_o      (dec_rd),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    in_entry              = '0;
    in_entry.pc           = in_pc_i;
    in_entry.ctrl         = dec_ctrl;
    in_entry.ctrl.illegal = dec_illegal;
    in_entry.rs1          = dec_rs1;
    in_entry.rs2          = dec_rs2;
    in_entry.rd           = dec_rd;
    in_entry.imm          = dec_imm;
  end

  // Only the held output is checked; a skid entry entered alongside the same load.
  assign hazard = out_valid_q && out_q.ctrl.dmem_read && (out_q.rd != 5'd0) && in_valid_i &&
                  ((dec_ctrl.use_rs1 && (dec_rs1 == out_q.rd)) ||
                   (dec_ctrl.use_rs2 && (dec_rs2 == out_q.rd)));

  assign out_load = out_ready_i || !out_valid_q;
  assign in_ready = (SKID ? !skid_valid_q : out_load) && !hazard && !flush_i;
  assign accept   = in_valid_i && in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_q       <= skid_d;
      end
    end
  end else begin : g_no_skid
    assign skid_valid_q = 1'b0;
    assign skid_q       = '0;
  end

  assign in_ready_o     = in_ready;
  assign hazard_stall_o = hazard;
  assign out_valid_o    = out_valid_q;
  assign out_pc_o       = out_q.pc;
  assign out_ctrl_o     = out_q.ctrl;
  assign out_rs1_o      = out_q.rs1;
  assign out_rs2_o      = out_q.rs2;
  assign out_rd_o       = out_q.rd;
  assign out_imm_o      = out_q.imm;
  assign out_illegal_o  = out_q.ctrl.illegal;

endmodule
